peg_l2_mac_rx_deframer: RTL and testbench

- Receive-side counterpart of the L2 MAC TX framer.
- Takes raw bytes from the RS packet interface and strips the preamble and SFD.
- Checks CRC-32 FCS and minimum length, strips the FCS, and pushes frames to the MAC LLC interface with an end-of-frame error flag.
- Decodes valid 802.3x PAUSE frames and drives `mac_pause_en` to MAC TX using a quanta timer.

---
 rtl/peg_l2_mac_rx_deframer_if.sv | 19 +
 rtl/peg_l2_mac_rx_deframer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_peg_l2_mac_rx_deframer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peg_l2_mac_rx_deframer_if.sv
// rtl/peg_l2_mac_rx_deframer_if.sv - byte stream bundle shared by the RS receive side and the LLC delivery side
//
// Ports (signals):
//   valid  byte valid, push-only (no ready)
//   sop    first byte of the burst/frame
//   eop    last byte of the burst/frame
//   data   DATA_W-bit byte
// Modports: master drives the stream, slave receives it.
interface peg_l2_mac_rx_deframer_if #(
   parameter int DATA_W = 8
);
   logic              valid;
   logic              sop;
   logic              eop;
   logic [DATA_W-1:0] data;

   modport master (output valid, output sop, output eop, output data);
   modport slave  (input  valid, input  sop, input  eop, input  data);
endinterface

// File: rtl/peg_l2_mac_rx_deframer.sv
// rtl/peg_l2_mac_rx_deframer.sv - L2 MAC receive deframer: preamble/SFD strip, FCS check/strip, PAUSE decode
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   config_l2_mac_rx_en         receive enable, sampled at sop in IDLE
//   config_l2_mac_rx_pause_en   enables PAUSE decode and the quanta timer
//   rs_rx  (slave)              raw bytes from RS: valid/sop/eop/data
//   llc_rx (master)             frame bytes DA..payload to LLC: valid/sop/eop/data
//   llc_rx_error                qualifies llc_rx eop: bad FCS, runt or aborted
//   mac_pause_en                high while the pause quanta is non-zero
//   l2_mac_rx_fsm_state         IDLE=0 PREAMBLE=1 DATA=2 DROP=3
//   l2_mac_rx_frm_cnt           good frames delivered, saturating
//   l2_mac_rx_err_cnt           errored or dropped frames, saturating
module peg_l2_mac_rx_deframer #(
   parameter int PKT_DATA_W = 8,
   parameter int PKT_SIZE_W = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            config_l2_mac_rx_en,
   input  logic                            config_l2_mac_rx_pause_en,
   peg_l2_mac_rx_deframer_if.slave         rs_rx,
   peg_l2_mac_rx_deframer_if.master        llc_rx,
   output logic                            llc_rx_error,
   output logic                            mac_pause_en,
   output logic [1:0]                      l2_mac_rx_fsm_state,
   output logic [15:0]                     l2_mac_rx_frm_cnt,
   output logic [15:0]                     l2_mac_rx_err_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_DROP     = 2'd3
   } state_t;

   typedef logic [PKT_DATA_W-1:0] byte_t;

   // Register residue of a good frame, written MSB-first; the shift register
   // itself is LSB-first, so it is bit-reversed before the compare.
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input byte_t d);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < PKT_DATA_W; i++) begin
         c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   state_t                  state_q, state_d, cur;
   logic [31:0]             crc_q, crc_d, crc_nx;
   logic [PKT_SIZE_W-1:0]   len_q, len_d, len_nx;
   byte_t [3:0]             dly_q, dly_d;      // [0] newest, [3] oldest
   logic [2:0]              dcnt_q, dcnt_d;    // bytes held in the delay line
   logic                    open_q, open_d;    // LLC sop sent, eop not yet
   logic                    pm_q, pm_d;        // PAUSE header still matching
   logic [15:0]             pq_q, pq_d;        // captured PAUSE quanta
   logic                    vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
   byte_t                   data_q, data_d;
   logic [15:0]             frm_q, frm_d, errc_q, errc_d;
   logic [16:0]             err_sum;
   logic [15:0]             quanta_q, quanta_d;
   logic [5:0]              presc_q, presc_d;
   logic                    pause_q, pause_d;
   logic                    frm_inc, load, frm_bad, p_care;
   logic [1:0]              err_add;
   byte_t                   p_ref;

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      len_d   = len_q;
      dly_d   = dly_q;
      dcnt_d  = dcnt_q;
      open_d  = open_q;
      pm_d    = pm_q;
      pq_d    = pq_q;
      vld_d   = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      err_d   = 1'b0;
      data_d  = data_q;
      frm_inc = 1'b0;
      err_add = 2'd0;
      load    = 1'b0;
      frm_bad = 1'b0;
      cur     = state_q;
      crc_nx  = crc_byte(crc_q, rs_rx.data);
      len_nx  = (&len_q) ? len_q : len_q + PKT_SIZE_W'(1);

      // Expected PAUSE header byte at the current DATA offset.
      p_care = 1'b0;
      p_ref  = '0;
      if (len_q < PKT_SIZE_W'(16)) begin
         p_care = 1'b1;
         case (len_q[3:0])
            4'd0:    p_ref = 8'h01;
            4'd1:    p_ref = 8'h80;
            4'd2:    p_ref = 8'hC2;
            4'd3:    p_ref = 8'h00;
            4'd4:    p_ref = 8'h00;
            4'd5:    p_ref = 8'h01;
            4'd12:   p_ref = 8'h88;
            4'd13:   p_ref = 8'h08;
            4'd14:   p_ref = 8'h00;
            4'd15:   p_ref = 8'h01;
            default: p_care = 1'b0;
         endcase
      end

      if (rs_rx.valid) begin
         // A new sop mid-burst aborts the current frame; the byte is then
         // handled as if the FSM were idle.
         if (rs_rx.sop && (state_q != ST_IDLE)) begin
            if (open_q) begin
               vld_d   = 1'b1;
               eop_d   = 1'b1;
               err_d   = 1'b1;
               data_d  = dly_q[3];
               open_d  = 1'b0;
               err_add = err_add + 2'd1;
            end
            cur = ST_IDLE;
         end

         case (cur)
            ST_IDLE: begin
               state_d = ST_IDLE;
               if (rs_rx.sop) begin
                  if (config_l2_mac_rx_en && (rs_rx.data == 8'h55) && !rs_rx.eop) begin
                     state_d = ST_PREAMBLE;
                  end else begin
                     err_add = err_add + 2'd1;
                     if (!rs_rx.eop) state_d = ST_DROP;
                  end
               end
            end
            ST_PREAMBLE: begin
               if (rs_rx.eop) begin
                  state_d = ST_IDLE;
                  err_add = err_add + 2'd1;
               end else if (rs_rx.data == 8'hD5) begin
                  state_d = ST_DATA;
                  crc_d   = 32'hFFFFFFFF;
                  len_d   = '0;
                  dcnt_d  = 3'd0;
                  pm_d    = 1'b1;
                  pq_d    = '0;
               end else if (rs_rx.data != 8'h55) begin
                  state_d = ST_DROP;
                  err_add = err_add + 2'd1;
               end
            end
            ST_DATA: begin
               crc_d = crc_nx;
               len_d = len_nx;
               dly_d = {dly_q[2:0], rs_rx.data};
               if (p_care && (rs_rx.data != p_ref)) pm_d = 1'b0;
               if (len_q == PKT_SIZE_W'(16)) pq_d[15:8] = rs_rx.data;
               if (len_q == PKT_SIZE_W'(17)) pq_d[7:0]  = rs_rx.data;
               // The last four bytes are the FCS, so output trails input by four.
               if (dcnt_q == 3'd4) begin
                  vld_d  = 1'b1;
                  sop_d  = !open_q;
                  data_d = dly_q[3];
                  open_d = 1'b1;
               end else begin
                  dcnt_d = dcnt_q + 3'd1;
               end
               if (rs_rx.eop) begin
                  state_d = ST_IDLE;
                  frm_bad = (bitrev32(crc_nx) != CRC_RESIDUE) || (len_nx < PKT_SIZE_W'(64));
                  if (dcnt_q == 3'd4) begin
                     eop_d  = 1'b1;
                     err_d  = frm_bad;
                     open_d = 1'b0;
                     if (frm_bad) err_add = err_add + 2'd1;
                     else         frm_inc = 1'b1;
                     load = !frm_bad && pm_q && config_l2_mac_rx_pause_en;
                  end else begin
                     err_add = err_add + 2'd1;
                  end
               end
            end
            default: begin
               if (rs_rx.eop) state_d = ST_IDLE;
            end
         endcase
      end

      frm_d   = (frm_inc && (frm_q != 16'hFFFF)) ? frm_q + 16'd1 : frm_q;
      err_sum = {1'b0, errc_q} + {15'd0, err_add};
      errc_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];

      // Pause timer: one quanta per 64 clocks; a reload beats a same-clock decrement.
      presc_d  = presc_q + 6'd1;
      quanta_d = quanta_q;
      if ((presc_q == 6'd63) && (quanta_q != 16'd0)) quanta_d = quanta_q - 16'd1;
      if (load) begin
         quanta_d = pq_q;
         presc_d  = 6'd0;
      end
      if (!config_l2_mac_rx_pause_en) quanta_d = 16'd0;
      pause_d = (quanta_d != 16'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         crc_q    <= 32'hFFFFFFFF;
         len_q    <= '0;
         dly_q    <= '0;
         dcnt_q   <= 3'd0;
         open_q   <= 1'b0;
         pm_q     <= 1'b0;
         pq_q     <= 16'd0;
         vld_q    <= 1'b0;
         sop_q    <= 1'b0;
         eop_q    <= 1'b0;
         err_q    <= 1'b0;
         data_q   <= '0;
         frm_q    <= 16'd0;
         errc_q   <= 16'd0;
         quanta_q <= 16'd0;
         presc_q  <= 6'd0;
         pause_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         crc_q    <= crc_d;
         len_q    <= len_d;
         dly_q    <= dly_d;
         dcnt_q   <= dcnt_d;
         open_q   <= open_d;
         pm_q     <= pm_d;
         pq_q     <= pq_d;
         vld_q    <= vld_d;
         sop_q    <= sop_d;
         eop_q    <= eop_d;
         err_q    <= err_d;
         data_q   <= data_d;
         frm_q    <= frm_d;
         errc_q   <= errc_d;
         quanta_q <= quanta_d;
         presc_q  <= presc_d;
         pause_q  <= pause_d;
      end
   end

   assign llc_rx.valid        = vld_q;
   assign llc_rx.sop          = sop_q;
   assign llc_rx.eop          = eop_q;
   assign llc_rx.data         = data_q;
   assign llc_rx_error        = err_q;
   assign mac_pause_en        = pause_q;
   assign l2_mac_rx_fsm_state = state_q;
   assign l2_mac_rx_frm_cnt   = frm_q;
   assign l2_mac_rx_err_cnt   = errc_q;

endmodule

// File: tb/tb_peg_l2_mac_rx_deframer.sv
// tb/tb_peg_l2_mac_rx_deframer.sv - self-checking bench for peg_l2_mac_rx_deframer
module tb_peg_l2_mac_rx_deframer;
   typedef logic [7:0] bq_t[$];

   typedef struct {
      int         plen;
      logic [7:0] pre3;
      logic [7:0] fx;
      logic       en;
      int         exp_n;
      logic       exp_err;
      int         dfrm;
      int         derr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_en, pause_en;
   logic        llc_rx_error, mac_pause_en;
   logic [1:0]  fsm;
   logic [15:0] frm_cnt, err_cnt;

   peg_l2_mac_rx_deframer_if #(.DATA_W(8)) rs ();
   peg_l2_mac_rx_deframer_if #(.DATA_W(8)) llc ();

   peg_l2_mac_rx_deframer dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .config_l2_mac_rx_en       (rx_en),
      .config_l2_mac_rx_pause_en (pause_en),
      .rs_rx                     (rs),
      .llc_rx                    (llc),
      .llc_rx_error              (llc_rx_error),
      .mac_pause_en              (mac_pause_en),
      .l2_mac_rx_fsm_state       (fsm),
      .l2_mac_rx_frm_cnt         (frm_cnt),
      .l2_mac_rx_err_cnt         (err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   checks = 0, failures = 0;
   logic [7:0] st_data[$];
   logic       st_sop[$], st_eop[$];
   logic [7:0] rx_bytes[$];
   logic       eop_err_q[$];
   int         eop_len_q[$];
   int         sop_cnt, first_vld_cyc, eop_cyc, da0_cyc, rise_cyc, fall_cyc, mon_len;
   logic       pause_prev = 1'b0;
   int         exp_frm = 0, exp_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_reg(input bq_t b);
      logic [31:0] c = 32'hFFFFFFFF;
      foreach (b[i]) begin
         c ^= {24'h0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   function automatic bq_t mk_body(input int n, input int seed);
      bq_t b;
      for (int i = 0; i < n; i++) b.push_back((i == 0) ? 8'h02 : 8'(i * 7 + seed * 13));
      return b;
   endfunction

   function automatic bq_t mk_pause(input logic [15:0] q);
      bq_t b;
      b = '{8'h01, 8'h80, 8'hC2, 8'h00, 8'h00, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE,
            8'h88, 8'h08, 8'h00, 8'h01};
      b.push_back(q[15:8]);
      b.push_back(q[7:0]);
      while (b.size() < 60) b.push_back(8'h00);
      return b;
   endfunction

   // Preamble (third byte replaceable), SFD, body, FCS LSB first; trunc>0 cuts the burst with no eop.
   task automatic add_frame(input bq_t b, input logic [7:0] pre3, input logic [7:0] fx, input int trunc);
      bq_t f;
      logic [31:0] fcs;
      for (int i = 0; i < 7; i++) f.push_back((i == 2) ? pre3 : 8'h55);
      f.push_back(8'hD5);
      foreach (b[i]) f.push_back(b[i]);
      fcs = ~crc_reg(b);
      f.push_back(fcs[7:0]);
      f.push_back(fcs[15:8]);
      f.push_back(fcs[23:16]);
      f.push_back(fcs[31:24] ^ fx);
      if (trunc > 0) while (f.size() > trunc) void'(f.pop_back());
      foreach (f[i]) begin
         st_data.push_back(f[i]);
         st_sop.push_back(i == 0);
         st_eop.push_back((trunc == 0) && (i == f.size() - 1));
      end
   endtask

   task automatic drive_stream();
      for (int i = 0; i < st_data.size(); i++) begin
         @(negedge clk);
         if (i == 8) da0_cyc = cyc;
         rs.valid = 1'b1;
         rs.sop   = st_sop[i];
         rs.eop   = st_eop[i];
         rs.data  = st_data[i];
      end
      @(negedge clk);
      rs.valid = 1'b0; rs.sop = 1'b0; rs.eop = 1'b0; rs.data = 8'h00;
      st_data.delete(); st_sop.delete(); st_eop.delete();
      repeat (10) @(negedge clk);
   endtask

   task automatic clear_mon();
      rx_bytes.delete(); eop_err_q.delete(); eop_len_q.delete();
      sop_cnt = 0; first_vld_cyc = -1; eop_cyc = -1;
   endtask

   task automatic chk_bytes(input string name, input bq_t exp);
      int mism = 0;
      for (int i = 0; i < exp.size() && i < rx_bytes.size(); i++) if (rx_bytes[i] !== exp[i]) mism++;
      chk({name, "_nbytes"}, rx_bytes.size(), exp.size());
      chk({name, "_data_mism"}, mism, 0);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (llc.valid) begin
            rx_bytes.push_back(llc.data);
            mon_len = llc.sop ? 1 : mon_len + 1;
            if (llc.sop) begin
               sop_cnt++;
               if (first_vld_cyc < 0) first_vld_cyc = cyc;
            end
            if (llc.eop) begin
               eop_err_q.push_back(llc_rx_error);
               eop_len_q.push_back(mon_len);
               eop_cyc = cyc;
            end
         end
         if (mac_pause_en && !pause_prev) rise_cyc = cyc;
         if (!mac_pause_en && pause_prev) fall_cyc = cyc;
         pause_prev = mac_pause_en;
      end
   end

   vec_t vt[10];
   bq_t  body, ba, bb, expb;

   initial begin : main
      vt[0] = '{60,  8'h55, 8'h00, 1'b1, 60,  1'b0, 1, 0};  // good 64-byte frame
      vt[1] = '{60,  8'h55, 8'h01, 1'b1, 60,  1'b1, 0, 1};  // last FCS byte flipped
      vt[2] = '{36,  8'h55, 8'h00, 1'b1, 36,  1'b1, 0, 1};  // 40-byte runt
      vt[3] = '{60,  8'h54, 8'h00, 1'b1, 0,   1'b0, 0, 1};  // bad preamble byte
      vt[4] = '{60,  8'h55, 8'h00, 1'b1, 60,  1'b0, 1, 0};  // good after bad preamble
      vt[5] = '{59,  8'h55, 8'h00, 1'b1, 59,  1'b1, 0, 1};  // 63 bytes: one short
      vt[6] = '{0,   8'h55, 8'h00, 1'b1, 0,   1'b0, 0, 1};  // only 4 DATA bytes
      vt[7] = '{1,   8'h55, 8'h00, 1'b1, 1,   1'b1, 0, 1};  // 5 DATA bytes: one byte out
      vt[8] = '{60,  8'h55, 8'h00, 1'b0, 0,   1'b0, 0, 1};  // rx_en low at sop
      vt[9] = '{100, 8'h55, 8'h00, 1'b1, 100, 1'b0, 1, 0};  // longer good frame

      rst_n = 1'b0; rx_en = 1'b1; pause_en = 1'b1; rise_cyc = -1; fall_cyc = -1; mon_len = 0;
      rs.valid = 1'b0; rs.sop = 1'b0; rs.eop = 1'b0; rs.data = 8'h00;
      clear_mon();
      repeat (3) @(negedge clk);
      chk("reset_outputs", {llc.valid, llc.sop, llc.eop, llc.data, llc_rx_error, mac_pause_en, fsm, frm_cnt, err_cnt}, 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int vi = 0; vi < 10; vi++) begin
         clear_mon();
         body  = mk_body(vt[vi].plen, vi);
         rx_en = vt[vi].en;
         add_frame(body, vt[vi].pre3, vt[vi].fx, 0);
         drive_stream();
         rx_en = 1'b1;
         exp_frm += vt[vi].dfrm;
         exp_err += vt[vi].derr;
         expb = '{};
         for (int i = 0; i < vt[vi].exp_n; i++) expb.push_back(body[i]);
         chk_bytes($sformatf("v%0d", vi), expb);
         chk($sformatf("v%0d_eops", vi), eop_err_q.size(), (vt[vi].exp_n > 0) ? 1 : 0);
         chk($sformatf("v%0d_sops", vi), sop_cnt, (vt[vi].exp_n > 0) ? 1 : 0);
         if (eop_err_q.size() == 1) chk($sformatf("v%0d_eop_err", vi), eop_err_q[0], vt[vi].exp_err);
         chk($sformatf("v%0d_frm_cnt", vi), frm_cnt, exp_frm);
         chk($sformatf("v%0d_err_cnt", vi), err_cnt, exp_err);
         if (vi == 0) chk("first_out_latency", first_vld_cyc - da0_cyc, 5);
         chk($sformatf("v%0d_fsm_idle", vi), fsm, 2'd0);
      end

      // Abort: a new sop after 20 output bytes closes the open frame with an errored eop.
      clear_mon();
      ba = mk_body(60, 20);
      bb = mk_body(60, 21);
      add_frame(ba, 8'h55, 8'h00, 32);
      add_frame(bb, 8'h55, 8'h00, 0);
      drive_stream();
      exp_err++; exp_frm++;
      expb = '{};
      for (int i = 0; i <= 20; i++) expb.push_back(ba[i]);
      foreach (bb[i]) expb.push_back(bb[i]);
      chk_bytes("abort", expb);
      chk("abort_eops", eop_err_q.size(), 2);
      if (eop_err_q.size() == 2) begin
         chk("abort_err0", eop_err_q[0], 1'b1);
         chk("abort_err1", eop_err_q[1], 1'b0);
         chk("abort_len0", eop_len_q[0], 21);
         chk("abort_len1", eop_len_q[1], 60);
      end
      chk("abort_frm_cnt", frm_cnt, exp_frm);
      chk("abort_err_cnt", err_cnt, exp_err);

      // PAUSE with quanta 3: high from the eop clock for exactly 192 clocks.
      clear_mon(); rise_cyc = -1; fall_cyc = -1;
      add_frame(mk_pause(16'h0003), 8'h55, 8'h00, 0);
      drive_stream();
      exp_frm++;
      chk("pause_nbytes", rx_bytes.size(), 60);
      chk("pause_rise", rise_cyc, eop_cyc);
      for (int k = 0; k < 300 && fall_cyc < 0; k++) @(negedge clk);
      chk("pause_width", fall_cyc - rise_cyc, 192);
      chk("pause_frm_cnt", frm_cnt, exp_frm);

      // Quanta 0 arriving mid-pause clears it on the eop clock.
      clear_mon(); rise_cyc = -1; fall_cyc = -1;
      add_frame(mk_pause(16'h0003), 8'h55, 8'h00, 0);
      drive_stream();
      chk("pause2_high", mac_pause_en, 1'b1);
      clear_mon();
      add_frame(mk_pause(16'h0000), 8'h55, 8'h00, 0);
      drive_stream();
      exp_frm += 2;
      chk("pause0_clear", fall_cyc, eop_cyc);
      chk("pause0_low", mac_pause_en, 1'b0);

      // Saturation of the error counter.
      @(negedge clk);
      force dut.errc_q = 16'hFFFF;
      @(posedge clk);
      #1 release dut.errc_q;
      clear_mon();
      add_frame(mk_body(60, 30), 8'h55, 8'h01, 0);
      drive_stream();
      chk("sat_err_cnt", err_cnt, 16'hFFFF);
      chk("sat_frm_cnt", frm_cnt, exp_frm);

      // Asynchronous reset mid-frame.
      clear_mon();
      add_frame(mk_body(60, 40), 8'h55, 8'h00, 0);
      fork
         drive_stream();
         begin
            repeat (40) @(negedge clk);
            chk("pre_reset_active", llc.valid, 1'b1);
            #2 rst_n = 1'b0;
            #1;
            chk("async_reset_outputs", {llc.valid, llc.sop, llc.eop, llc.data, llc_rx_error, mac_pause_en, fsm, frm_cnt, err_cnt}, 64'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      chk("reset_no_eop", eop_err_q.size(), 0);
      chk("reset_fsm_idle", fsm, 2'd0);
      clear_mon();
      add_frame(mk_body(60, 50), 8'h55, 8'h00, 0);
      drive_stream();
      chk("post_reset_frm_cnt", frm_cnt, 16'd1);
      chk("post_reset_err_cnt", err_cnt, 16'd0);
      chk("post_reset_nbytes", rx_bytes.size(), 60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
